// File: rtl/gpu_cmd_pkg.sv
// Shared definitions for the GPU command path: word geometry, the opcode
// field position and the byte-assembly counter encoding. The GPU decoder
// imports this package too, so field positions stay in one place.
package gpu_cmd_pkg;

    localparam int CmdWidth    = 32;
    localparam int BytesPerCmd = 4;

    // Opcode field of a command word; the first byte sent by the host.
    localparam int OpcodeMsb = 31;
    localparam int OpcodeLsb = 24;

    // Which byte of the current command word arrives next.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } byte_cnt_e;

    // Advance the byte counter after an accepted byte; BYTE3 wraps to BYTE0.
    function automatic byte_cnt_e next_byte_cnt(input byte_cnt_e cur);
        case (cur)
            BYTE0:   return BYTE1;
            BYTE1:   return BYTE2;
            BYTE2:   return BYTE3;
            default: return BYTE0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. The head word is visible on
// 'head' as soon as it is written; 'head' reads 0 while the FIFO is empty.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
    parameter int Width = 32,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [Width-1:0]         push_data,
    input  logic                     pop,
    output logic [Width-1:0]         head,
    output logic [$clog2(Depth):0]   level
);

    localparam int AddrW  = $clog2(Depth);
    localparam int LevelW = AddrW + 1;

    logic [Width-1:0]  mem [Depth];
    logic [AddrW-1:0]  wr_ptr;
    logic [AddrW-1:0]  rd_ptr;
    logic [LevelW-1:0] count;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LevelW'(Depth));
    assign do_pop  = pop && !empty;
    // A pop in the same edge frees the slot, so a full FIFO may still push.
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AddrW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AddrW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LevelW'(1);
                2'b01:   count <= count - LevelW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array write port.
    // NOTE: the storage is deliberately not reset; a cleared count makes the
    // stale contents unreachable, and 'head' is forced to 0 while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = empty ? '0 : mem[rd_ptr];
    assign level = count;

endmodule

// File: rtl/gpu_cmd_packer.sv
// Packs a host byte stream MSB-first into 32-bit GPU command words, queues
// them in a FWFT FIFO and presents them on a dv/ready command port. A
// partial word that sits idle for TimeoutCycles is dropped so the host can
// resynchronise on a word boundary.
module gpu_cmd_packer
    import gpu_cmd_pkg::*;
#(
    parameter int FifoDepth     = 4,
    parameter int TimeoutCycles = 50000000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        byte_valid,
    input  logic [7:0]                  byte_data,
    output logic                        byte_ready,
    output logic                        cmd_dv,
    output logic [CmdWidth-1:0]         cmd_din,
    input  logic                        cmd_ready,
    output logic                        resync_err,
    output logic [$clog2(FifoDepth):0]  level
);

    localparam int LevelW   = $clog2(FifoDepth) + 1;
    localparam int TimerW   = $clog2(TimeoutCycles);
    localparam int PartialW = (BytesPerCmd - 1) * 8;

    byte_cnt_e             byte_cnt;
    logic [PartialW-1:0]   partial;
    logic [TimerW-1:0]     timer;
    logic                  resync_q;

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  timeout_hit;
    logic [CmdWidth-1:0]   push_word;

    // The 4th byte needs a free slot; a same-cycle pop is not counted on.
    assign byte_ready  = (byte_cnt != BYTE3) || (level != LevelW'(FifoDepth));
    assign accept      = byte_valid && byte_ready;
    assign push        = accept && (byte_cnt == BYTE3);
    assign push_word   = {partial, byte_data};
    assign cmd_dv      = (level != '0);
    assign pop         = cmd_dv && cmd_ready;
    // An accepted byte in the expiry cycle wins over the timeout.
    assign timeout_hit = !accept && (byte_cnt != BYTE0) &&
                         (timer == TimerW'(TimeoutCycles - 1));

    // Byte assembly, inter-byte timeout and the registered resync pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= BYTE0;
            partial  <= '0;
            timer    <= '0;
            resync_q <= 1'b0;
        end else begin
            resync_q <= timeout_hit;
            if (accept) begin
                byte_cnt <= next_byte_cnt(byte_cnt);
                partial  <= push ? '0 : {partial[PartialW-9:0], byte_data};
                timer    <= '0;
            end else if (timeout_hit) begin
                byte_cnt <= BYTE0;
                partial  <= '0;
                timer    <= '0;
            end else if (byte_cnt != BYTE0) begin
                timer    <= timer + TimerW'(1);
            end else begin
                timer    <= '0;
            end
        end
    end

    assign resync_err = resync_q;

    sync_fifo_fwft #(
        .Width (CmdWidth),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (cmd_din),
        .level     (level)
    );

endmodule

// File: tb/tb_gpu_cmd_packer.sv
// Self-checking bench for gpu_cmd_packer with a short timeout and depth 4.
module tb_gpu_cmd_packer;

    localparam int Depth = 4;
    localparam int Tmo   = 16;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          cmd_dv;
    logic [31:0]   cmd_din;
    logic          cmd_ready;
    logic          resync_err;
    logic [LW-1:0] level;

    int total = 0;
    int bad   = 0;

    gpu_cmd_packer #(
        .FifoDepth     (Depth),
        .TimeoutCycles (Tmo)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .cmd_dv     (cmd_dv),
        .cmd_din    (cmd_din),
        .cmd_ready  (cmd_ready),
        .resync_err (resync_err),
        .level      (level)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte until it is accepted (bounded), then drop byte_valid.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (byte_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_byte_stall: byte_ready=%b after %0d cycles, want 1", byte_ready, n);
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        cmd_ready  = 1'b0;
        tick();
        tick();
        total += 4;
        if (cmd_dv !== 1'b0) begin bad++; $display("FAIL reset_dv: got %b want 0", cmd_dv); end
        if (cmd_din !== 32'h0) begin bad++; $display("FAIL reset_din: got %h want 00000000", cmd_din); end
        if (level !== LW'(0)) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
        if (resync_err !== 1'b0) begin bad++; $display("FAIL reset_resync: got %b want 0", resync_err); end
        rst_n = 1'b1;
        tick();
        total++;
        if (byte_ready !== 1'b1) begin bad++; $display("FAIL reset_byte_ready: got %b want 1", byte_ready); end
    endtask

    task automatic test_single();
        cmd_ready = 1'b1;
        send_word(32'hDEADBEEF);
        total += 3;
        if (cmd_dv !== 1'b1) begin bad++; $display("FAIL single_dv: got %b want 1", cmd_dv); end
        if (cmd_din !== 32'hDEADBEEF) begin bad++; $display("FAIL single_din: got %h want deadbeef", cmd_din); end
        if (level !== LW'(1)) begin bad++; $display("FAIL single_level: got %0d want 1", level); end
        tick();
        total += 2;
        if (cmd_dv !== 1'b0) begin bad++; $display("FAIL single_dv_drop: got %b want 0", cmd_dv); end
        if (level !== LW'(0)) begin bad++; $display("FAIL single_level_drain: got %0d want 0", level); end
    endtask

    task automatic test_fill();
        logic [31:0] w [5];
        logic [31:0] got [$];
        int          n;
        logic        taking;
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) w[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            send_word(w[i]);
            total++;
            if (level !== LW'(i + 1)) begin bad++; $display("FAIL fill_level%0d: got %0d want %0d", i, level, i + 1); end
        end
        for (int i = 3; i >= 1; i--) send_byte(w[4][i*8 +: 8]);
        byte_valid = 1'b1;
        byte_data  = w[4][7:0];
        for (int k = 0; k < 3; k++) begin
            total += 3;
            if (byte_ready !== 1'b0) begin bad++; $display("FAIL fill_byte_ready: got %b want 0", byte_ready); end
            if (level !== LW'(Depth)) begin bad++; $display("FAIL fill_full_level: got %0d want %0d", level, Depth); end
            if (cmd_din !== w[0]) begin bad++; $display("FAIL fill_head: got %h want %h", cmd_din, w[0]); end
            tick();
        end
        cmd_ready = 1'b1;
        n = 0;
        while (got.size() < 5 && n < 40) begin
            if (cmd_dv) got.push_back(cmd_din);
            taking = byte_valid && byte_ready;
            tick();
            if (taking) byte_valid = 1'b0;
            n++;
        end
        total++;
        if (got.size() != 5) begin bad++; $display("FAIL fill_count: got %0d words want 5", got.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                total++;
                if (got[i] !== w[i]) begin bad++; $display("FAIL fill_order%0d: got %h want %h", i, got[i], w[i]); end
            end
        end
        total += 2;
        if (level !== LW'(0)) begin bad++; $display("FAIL fill_drain_level: got %0d want 0", level); end
        if (byte_valid !== 1'b0) begin bad++; $display("FAIL fill_fifth_accept: byte_valid still %b, want 0", byte_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        w = $urandom;
        cmd_ready = 1'b0;
        send_word(w);
        for (int k = 0; k < 10; k++) begin
            total += 2;
            if (cmd_dv !== 1'b1) begin bad++; $display("FAIL bp_dv%0d: got %b want 1", k, cmd_dv); end
            if (cmd_din !== w) begin bad++; $display("FAIL bp_din%0d: got %h want %h", k, cmd_din, w); end
            tick();
        end
        cmd_ready = 1'b1;
        tick();
        total++;
        if (cmd_dv !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", cmd_dv); end
    endtask

    task automatic test_timeout();
        cmd_ready = 1'b1;
        send_byte(8'h11);
        send_byte(8'h22);
        for (int i = 1; i <= Tmo; i++) begin
            tick();
            total++;
            if (resync_err !== (i == Tmo)) begin
                bad++;
                $display("FAIL timeout_pulse_idle%0d: got %b want %b", i, resync_err, (i == Tmo));
            end
        end
        tick();
        total += 2;
        if (resync_err !== 1'b0) begin bad++; $display("FAIL timeout_single_pulse: got %b want 0", resync_err); end
        if (level !== LW'(0)) begin bad++; $display("FAIL timeout_level: got %0d want 0", level); end
        send_word(32'h01020304);
        total += 2;
        if (cmd_dv !== 1'b1) begin bad++; $display("FAIL resync_dv: got %b want 1", cmd_dv); end
        if (cmd_din !== 32'h01020304) begin bad++; $display("FAIL resync_word: got %h want 01020304", cmd_din); end
        tick();
        // A byte arriving in the expiry cycle must be kept.
        send_byte(8'hAA);
        for (int i = 1; i < Tmo; i++) tick();
        send_byte(8'hBB);
        total++;
        if (resync_err !== 1'b0) begin bad++; $display("FAIL edge_no_resync: got %b want 0", resync_err); end
        send_byte(8'hCC);
        send_byte(8'hDD);
        total += 2;
        if (cmd_din !== 32'hAABBCCDD) begin bad++; $display("FAIL edge_word: got %h want aabbccdd", cmd_din); end
        if (resync_err !== 1'b0) begin bad++; $display("FAIL edge_no_resync_late: got %b want 0", resync_err); end
        tick();
    endtask

    task automatic test_async_reset();
        cmd_ready = 1'b0;
        send_word($urandom);
        send_word($urandom);
        send_byte(8'h5A);
        send_byte(8'hA5);
        total++;
        if (level !== LW'(2)) begin bad++; $display("FAIL areset_pre_level: got %0d want 2", level); end
        #2;
        rst_n = 1'b0;
        #1;
        total += 3;
        if (cmd_dv !== 1'b0) begin bad++; $display("FAIL areset_dv: got %b want 0", cmd_dv); end
        if (level !== LW'(0)) begin bad++; $display("FAIL areset_level: got %0d want 0", level); end
        if (cmd_din !== 32'h0) begin bad++; $display("FAIL areset_din: got %h want 00000000", cmd_din); end
        tick();
        rst_n = 1'b1;
        tick();
        cmd_ready = 1'b1;
        send_word(32'hCAFEF00D);
        total += 2;
        if (cmd_dv !== 1'b1) begin bad++; $display("FAIL areset_post_dv: got %b want 1", cmd_dv); end
        if (cmd_din !== 32'hCAFEF00D) begin bad++; $display("FAIL areset_post_word: got %h want cafef00d", cmd_din); end
        tick();
    endtask

    // Random traffic checked against a word-queue model of the packer.
    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] acc = '0;
        logic [31:0] exp_head;
        int          pcnt = 0;
        int          idle = 0;
        int          pushed = 0;
        int          popped = 0;
        int          cyc = 0;
        logic        exp_br;
        logic        take;
        byte_valid = 1'b0;
        cmd_ready  = 1'b0;
        while ((pushed < 1000 || exp_q.size() != 0) && cyc < 40000) begin
            exp_br   = !(pcnt == 3 && exp_q.size() == Depth);
            exp_head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
            total += 5;
            if (level !== LW'(exp_q.size())) begin bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", cyc, level, exp_q.size()); end
            if (cmd_dv !== (exp_q.size() != 0)) begin bad++; $display("FAIL rnd_dv@%0d: got %b want %b", cyc, cmd_dv, exp_q.size() != 0); end
            if (cmd_din !== exp_head) begin bad++; $display("FAIL rnd_din@%0d: got %h want %h", cyc, cmd_din, exp_head); end
            if (byte_ready !== exp_br) begin bad++; $display("FAIL rnd_byte_ready@%0d: got %b want %b", cyc, byte_ready, exp_br); end
            if (resync_err !== 1'b0) begin bad++; $display("FAIL rnd_resync@%0d: got %b want 0", cyc, resync_err); end
            if (pushed < 1000) begin
                byte_valid = ($urandom_range(0, 1) == 1) || (idle >= 8);
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = 1'b0;
            end
            cmd_ready = ($urandom_range(0, 1) == 1) || (idle >= 8) || (pushed >= 1000);
            take = byte_valid && exp_br;
            if (exp_q.size() != 0 && cmd_ready) begin
                void'(exp_q.pop_front());
                popped++;
            end
            if (take) begin
                acc  = {acc[23:0], byte_data};
                pcnt++;
                idle = 0;
                if (pcnt == 4) begin
                    exp_q.push_back(acc);
                    pushed++;
                    pcnt = 0;
                end
            end else if (pcnt != 0) begin
                idle++;
            end else begin
                idle = 0;
            end
            tick();
            cyc++;
        end
        byte_valid = 1'b0;
        total += 2;
        if (cyc >= 40000) begin bad++; $display("FAIL rnd_budget: ran %0d cycles, want < 40000", cyc); end
        if (popped != 1000) begin bad++; $display("FAIL rnd_popped: got %0d want 1000", popped); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_timeout();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
